// File: rtl/grid_io_multi_subtile.sv
// Perimeter I/O tile: NUM_SUBTILES embedded-I/O subtiles configured by one chain segment,
// with polarity inversion, optional input register and a chain-length check gating the pads.
module grid_io_multi_subtile #(
  parameter int NUM_SUBTILES = 2,
  parameter int CFG_BITS     = 3
) (
  input  logic                    prog_clk,
  input  logic                    prog_reset,
  input  logic                    IO_ISOL_N,
  input  logic                    cfg_en,
  input  logic                    ccff_head,
  output logic                    ccff_tail,
  input  logic [0:NUM_SUBTILES-1] gfpga_pad_EMBEDDED_IO_ISOLN_SOC_IN,
  output logic [0:NUM_SUBTILES-1] gfpga_pad_EMBEDDED_IO_ISOLN_SOC_OUT,
  output logic [0:NUM_SUBTILES-1] gfpga_pad_EMBEDDED_IO_ISOLN_SOC_DIR,
  input  logic [0:NUM_SUBTILES-1] fabric_outpad,
  output logic [0:NUM_SUBTILES-1] fabric_inpad,
  output logic                    cfg_done,
  output logic                    cfg_err
);

  localparam int L  = CFG_BITS * NUM_SUBTILES;
  localparam int CW = $clog2(L + 2);
  localparam logic [CW-1:0] CNT_LEN = CW'(L);
  localparam logic [CW-1:0] CNT_MAX = CW'(L + 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE, ERR} state_t;

  state_t                  state;
  state_t                  state_next;
  logic [L-1:0]            cfg;
  logic [CW-1:0]           cnt;
  logic [0:NUM_SUBTILES-1] q;
  logic                    active;

  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      state <= IDLE;
      cfg   <= '0;
      cnt   <= '0;
      q     <= '0;
    end else begin
      state <= state_next;
      if (cfg_en) begin
        cfg <= {cfg[L-2:0], ccff_head};
        // A fresh burst restarts the count; within a burst it saturates at L+1 so overlong is detectable.
        if (state != SHIFT) cnt <= CNT_ONE;
        else if (cnt != CNT_MAX) cnt <= cnt + CNT_ONE;
      end
      // The input register keeps sampling while isolated so it is valid on release.
      for (int k = 0; k < NUM_SUBTILES; k++)
        q[k] <= gfpga_pad_EMBEDDED_IO_ISOLN_SOC_IN[k] ^ cfg[CFG_BITS*k+1];
    end
  end

  always_comb begin
    state_next = state;
    cfg_done   = 1'b0;
    cfg_err    = 1'b0;
    case (state)
      IDLE:    if (cfg_en) state_next = SHIFT;
      SHIFT:   if (!cfg_en) state_next = (cnt == CNT_LEN) ? DONE : ERR;
      DONE: begin
        cfg_done = 1'b1;
        if (cfg_en) state_next = SHIFT;
      end
      ERR: begin
        cfg_err = 1'b1;
        if (cfg_en) state_next = SHIFT;
      end
      default: state_next = IDLE;
    endcase
  end

  assign active    = (state == DONE) & IO_ISOL_N;
  assign ccff_tail = cfg[L-1];

  always_comb begin
    gfpga_pad_EMBEDDED_IO_ISOLN_SOC_DIR = '1;
    gfpga_pad_EMBEDDED_IO_ISOLN_SOC_OUT = '0;
    fabric_inpad                        = '0;
    for (int k = 0; k < NUM_SUBTILES; k++) begin
      if (active) begin
        gfpga_pad_EMBEDDED_IO_ISOLN_SOC_DIR[k] = cfg[CFG_BITS*k];
        if (cfg[CFG_BITS*k]) begin
          fabric_inpad[k] = cfg[CFG_BITS*k+2] ? q[k]
                          : (gfpga_pad_EMBEDDED_IO_ISOLN_SOC_IN[k] ^ cfg[CFG_BITS*k+1]);
        end else begin
          gfpga_pad_EMBEDDED_IO_ISOLN_SOC_OUT[k] = fabric_outpad[k] ^ cfg[CFG_BITS*k+1];
        end
      end
    end
  end

endmodule

// File: tb/tb_grid_io_multi_subtile.sv
// Bench for grid_io_multi_subtile: directed scenarios plus randomized cycles against a
// queue-based reference model of the chain, bit count and pad behaviour.
module tb_grid_io_multi_subtile;

  localparam int N = 2;
  localparam int L = 3 * N;

  // clock / reset
  logic prog_clk = 1'b0;
  always #5 prog_clk = ~prog_clk;

  logic         prog_reset;
  logic         isol_n;
  logic         cfg_en;
  logic         ccff_head;
  logic         ccff_tail;
  logic [0:N-1] soc_in;
  logic [0:N-1] soc_out;
  logic [0:N-1] soc_dir;
  logic [0:N-1] fabric_outpad;
  logic [0:N-1] fabric_inpad;
  logic         cfg_done;
  logic         cfg_err;

  grid_io_multi_subtile #(.NUM_SUBTILES(N), .CFG_BITS(3)) dut (
    .prog_clk                            (prog_clk),
    .prog_reset                          (prog_reset),
    .IO_ISOL_N                           (isol_n),
    .cfg_en                              (cfg_en),
    .ccff_head                           (ccff_head),
    .ccff_tail                           (ccff_tail),
    .gfpga_pad_EMBEDDED_IO_ISOLN_SOC_IN  (soc_in),
    .gfpga_pad_EMBEDDED_IO_ISOLN_SOC_OUT (soc_out),
    .gfpga_pad_EMBEDDED_IO_ISOLN_SOC_DIR (soc_dir),
    .fabric_outpad                       (fabric_outpad),
    .fabric_inpad                        (fabric_inpad),
    .cfg_done                            (cfg_done),
    .cfg_err                             (cfg_err)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // reference model: the chain is a queue, exp_q[i] is chain position i
  logic [0:0]   exp_q[$];
  int           m_cnt;
  bit           m_shifting;
  bit           m_done;
  bit           m_err;
  logic [0:N-1] m_q;

  function automatic void model_reset();
    exp_q.delete();
    for (int i = 0; i < L; i++) exp_q.push_back(1'b0);
    m_cnt      = 0;
    m_shifting = 0;
    m_done     = 0;
    m_err      = 0;
    m_q        = '0;
  endfunction

  // advance the model by one rising edge, using the inputs currently applied
  function automatic void model_step();
    if (prog_reset) begin
      model_reset();
      return;
    end
    for (int k = 0; k < N; k++) m_q[k] = soc_in[k] ^ exp_q[3*k+1][0];
    if (cfg_en) begin
      if (!m_shifting) m_cnt = 1;
      else if (m_cnt < L + 1) m_cnt++;
      exp_q.push_front(ccff_head);
      void'(exp_q.pop_back());
      m_shifting = 1;
      m_done     = 0;
      m_err      = 0;
    end else if (m_shifting) begin
      m_shifting = 0;
      m_done     = (m_cnt == L);
      m_err      = (m_cnt != L);
    end
  endfunction

  task automatic check_all(input string tag);
    logic [0:N-1] e_dir, e_out, e_in;
    logic         act, d, inv, rg;
    act = m_done & isol_n;
    for (int k = 0; k < N; k++) begin
      d   = exp_q[3*k][0];
      inv = exp_q[3*k+1][0];
      rg  = exp_q[3*k+2][0];
      e_dir[k] = act ? d : 1'b1;
      e_out[k] = (act && !d) ? (fabric_outpad[k] ^ inv) : 1'b0;
      e_in[k]  = (act && d) ? (rg ? m_q[k] : (soc_in[k] ^ inv)) : 1'b0;
    end
    check({tag, ".done"}, 32'(cfg_done), 32'(m_done));
    check({tag, ".err"},  32'(cfg_err),  32'(m_err));
    check({tag, ".tail"}, 32'(ccff_tail), 32'(exp_q[L-1]));
    check({tag, ".dir"},  32'(soc_dir), 32'(e_dir));
    check({tag, ".out"},  32'(soc_out), 32'(e_out));
    check({tag, ".inpad"}, 32'(fabric_inpad), 32'(e_in));
  endtask

  // driver tasks
  task automatic tick();
    model_step();
    @(posedge prog_clk);
    #1;
  endtask

  task automatic shift_bits(input logic [15:0] w, input int n, input string tag);
    for (int i = n - 1; i >= 0; i--) begin
      cfg_en    = 1'b1;
      ccff_head = w[i];
      #1 check_all(tag);
      tick();
    end
  endtask

  task automatic idle(input string tag);
    cfg_en = 1'b0;
    #1 check_all(tag);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int burst;
    prog_reset    = 1'b1;
    isol_n        = 1'b1;
    cfg_en        = 1'b0;
    ccff_head     = 1'b0;
    soc_in        = '0;
    fabric_outpad = '0;
    model_reset();
    @(posedge prog_clk); #1;
    tick();
    prog_reset = 1'b0;
    #1 check_all("reset");
    check("reset.dir_all1", 32'(soc_dir), 32'h3);
    check("reset.tail0", 32'(ccff_tail), 32'h0);

    // dir0=1 inv0=0 reg0=0, dir1=0 inv1=1 reg1=0
    shift_bits(16'b010001, 6, "cfg1");
    idle("cfg1.drop");
    soc_in = 2'b10; fabric_outpad = 2'b01;
    #1 check_all("cfg1.pads");
    check("cfg1.done", 32'(cfg_done), 32'h1);
    check("cfg1.dir", 32'(soc_dir), 32'h2);
    check("cfg1.inpad0", 32'(fabric_inpad[0]), 32'h1);
    check("cfg1.out1", 32'(soc_out[1]), 32'h0);

    // short segment
    shift_bits(16'b10101, 5, "short");
    idle("short.drop");
    #1 check("short.err", 32'(cfg_err), 32'h1);
    check("short.dir", 32'(soc_dir), 32'h3);
    check("short.out", 32'(soc_out), 32'h0);
    check("short.inpad", 32'(fabric_inpad), 32'h0);

    // overlong segment, then exact
    shift_bits(16'b1100110, 7, "long");
    idle("long.drop");
    #1 check("long.err", 32'(cfg_err), 32'h1);
    shift_bits(16'b010001, 6, "exact");
    idle("exact.drop");
    #1 check("exact.done", 32'(cfg_done), 32'h1);
    check("exact.err", 32'(cfg_err), 32'h0);

    // registered, inverted input on subtile 0
    shift_bits(16'b000111, 6, "reg");
    idle("reg.drop");
    soc_in[0] = 1'b0;
    #1 check_all("reg.lo");
    tick();
    #1 check("reg.settle", 32'(fabric_inpad[0]), 32'h1);
    soc_in[0] = 1'b1;
    #1 check("reg.hold", 32'(fabric_inpad[0]), 32'h1);
    tick();
    #1 check("reg.flip", 32'(fabric_inpad[0]), 32'h0);
    check_all("reg.after");

    // isolation for three cycles in DONE
    fabric_outpad = 2'b11;
    for (int c = 0; c < 3; c++) begin
      isol_n = 1'b0;
      #1 check("isol.dir", 32'(soc_dir), 32'h3);
      check("isol.out", 32'(soc_out), 32'h0);
      check("isol.inpad", 32'(fabric_inpad), 32'h0);
      check("isol.done", 32'(cfg_done), 32'h1);
      tick();
    end
    isol_n = 1'b1;
    #1 check("isol.release_dir", 32'(soc_dir), 32'h2);
    check_all("isol.release");

    // reset mid-shift, reset wins over cfg_en
    shift_bits(16'b111, 3, "rst.part");
    prog_reset = 1'b1; cfg_en = 1'b1; ccff_head = 1'b1;
    tick();
    prog_reset = 1'b0; cfg_en = 1'b0;
    #1 check_all("rst.vals");
    check("rst.tail", 32'(ccff_tail), 32'h0);
    check("rst.done", 32'(cfg_done), 32'h0);
    check("rst.inpad", 32'(fabric_inpad), 32'h0);
    shift_bits(16'b100001, 6, "rst.full");
    #1 check("rst.tail_first", 32'(ccff_tail), 32'h1);
    idle("rst.drop");
    #1 check("rst.done_after", 32'(cfg_done), 32'h1);

    // randomized cycles
    burst = 0;
    for (int c = 0; c < 600; c++) begin
      if (burst == 0 && $urandom_range(0, 3) == 0) burst = $urandom_range(4, 8);
      cfg_en        = (burst > 0);
      if (burst > 0) burst--;
      ccff_head     = 1'($urandom_range(0, 1));
      soc_in        = 2'($urandom_range(0, 3));
      fabric_outpad = 2'($urandom_range(0, 3));
      isol_n        = ($urandom_range(0, 7) != 0);
      prog_reset    = ($urandom_range(0, 79) == 0);
      if (prog_reset) burst = 0;
      #1 check_all("rand");
      tick();
    end
    prog_reset = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/grid_io_multi_subtile.md
# grid_io_multi_subtile

Parametrised I/O grid tile for the fabric perimeter: NUM_SUBTILES embedded-I/O subtiles behind one configuration-chain segment, clocked by prog_clk. It adds per-subtile polarity inversion and an optional input register. A chain-length checker holds every pad isolated until a complete, correctly sized bitstream segment has been shifted in. It replaces the fixed two-subtile, one-bit-per-subtile I/O tiles on all four sides.

## Interface
Parameters:
- NUM_SUBTILES, 2: number of I/O subtiles (≥1).
- CFG_BITS, 3 (fixed): config bits per subtile. Chain length L = 3*NUM_SUBTILES.

Ports:
- prog_clk  in  1  the only clock for this block; all state updates on its rising edge.
- prog_reset  in  1  reset, synchronous, active-high.
- IO_ISOL_N  in  1  global isolation, active-low; combinational effect.
- cfg_en  in  1  shift enable; one chain bit is shifted per cycle while high.
- ccff_head  in  1  chain serial input.
- ccff_tail  out  1  chain serial output = cfg[L-1].
- gfpga_pad_EMBEDDED_IO_ISOLN_SOC_IN  in  [0:NUM_SUBTILES-1]  pad input from SoC.
- gfpga_pad_EMBEDDED_IO_ISOLN_SOC_OUT  out  [0:NUM_SUBTILES-1]  pad output to SoC.
- gfpga_pad_EMBEDDED_IO_ISOLN_SOC_DIR  out  [0:NUM_SUBTILES-1]  1 = pad is input (driver off), 0 = pad drives.
- fabric_outpad  in  [0:NUM_SUBTILES-1]  fabric-to-pad data.
- fabric_inpad  out  [0:NUM_SUBTILES-1]  pad-to-fabric data.
- cfg_done  out  1  1 in state DONE.
- cfg_err  out  1  1 in state ERR.

## Operation
- Chain: cfg[0..L-1]. On a cycle with cfg_en=1: cfg[0]<=ccff_head, cfg[i]<=cfg[i-1]. Holds otherwise. The first bit shifted ends in cfg[L-1].
- Subtile k owns three bits:
  - dir_k = cfg[3k]: 1 = input mode.
  - inv_k = cfg[3k+1]: invert data in both directions.
  - reg_k = cfg[3k+2]: register the input path.
- Bit counter cnt: width clog2(L+2), saturates at L+1.
  - In the first cycle that cfg_en=1 while the state is not SHIFT: cnt<=1.
  - In SHIFT with cfg_en=1: cnt<=min(cnt+1, L+1).
- FSM states, IDLE (reset), SHIFT, DONE, ERR:
  - IDLE, DONE or ERR with cfg_en=1 → SHIFT.
  - SHIFT with cfg_en=1 → stays in SHIFT.
  - SHIFT with cfg_en=0 → DONE if cnt==L, else ERR (covers short and overlong segments).
  - DONE or ERR with cfg_en=0 → hold.
- active = (state==DONE) & IO_ISOL_N.
- Input register: q_k <= SOC_IN[k]^inv_k every cycle; reset value 0.
- Per subtile k:
  - SOC_DIR[k] = active ? dir_k : 1.
  - SOC_OUT[k] = (active & ~dir_k) ? fabric_outpad[k]^inv_k : 0.
  - fabric_inpad[k] = (active & dir_k) ? (reg_k ? q_k : SOC_IN[k]^inv_k) : 0.

## Timing
- Reset values:
  - cfg, cnt and q are all 0; state is IDLE.
  - Outputs: cfg_done=0, cfg_err=0, ccff_tail=0, SOC_DIR all 1, SOC_OUT all 0, fabric_inpad all 0.
- ccff_tail changes one cycle after each shifting edge. Chain latency head→tail is L cycles of cfg_en=1.
- cfg_done/cfg_err assert in the cycle after the first cfg_en=0 sample following a shift burst, i.e. registered state.
- Re-entering SHIFT clears cfg_done/cfg_err on the next edge. Pads are isolated from that edge.
- IO_ISOL_N is purely combinational: pads isolate or release in the same cycle, with no state change.
- Input path latency:
  - reg_k=0: combinational.
  - reg_k=1: 1 prog_clk cycle.
  - q keeps sampling during isolation, so the value is valid immediately on release.
- Output path is always combinational.
- prog_reset mid-shift: on the next edge, cfg and cnt are cleared and the state goes to IDLE. prog_reset has priority over cfg_en.
- A cfg_en pulse after DONE restarts the count at 1. Configuration bits change with each shift, but pads stay isolated throughout.

## Test plan
- NUM_SUBTILES=2, L=6. Reset, then shift 6 bits so that dir0=1, inv0=0, reg0=0 and dir1=0, inv1=1, reg1=0; drop cfg_en; IO_ISOL_N=1. Expect:
  - cfg_done=1 one cycle later;
  - SOC_DIR=[1,0];
  - SOC_IN[0]=1 → fabric_inpad[0]=1 in the same cycle;
  - fabric_outpad[1]=1 → SOC_OUT[1]=0.
- Shift only 5 bits, then drop cfg_en. Expect cfg_err=1, SOC_DIR=[1,1], SOC_OUT=0, fabric_inpad=0.
- Shift 7 bits. Expect cfg_err=1 (counter saturated at 7). Then shift exactly 6 bits. Expect cfg_done=1 and cfg_err=0.
- Set dir0=1, reg0=1, inv0=1 and toggle SOC_IN[0] 0→1. Expect fabric_inpad[0] to go 1→0 exactly one cycle later.
- In DONE, pull IO_ISOL_N=0 for 3 cycles. Expect all pads isolated in the same cycles, cfg_done to stay 1, and outputs restored the cycle IO_ISOL_N returns to 1.
- Assert prog_reset after 3 of 6 shift bits, then resume. Expect:
  - all reset values next cycle;
  - ccff_tail=0;
  - a fresh full 6-bit shift reaches DONE;
  - ccff_tail equals the first shifted bit after 6 shifts.
